// File: rtl/data_memory.sv
// Register-file data memory: DEPTH words of DATA_WIDTH bits, combinational read,
// synchronous single-word write, asynchronous clear of every word on reset.

module data_memory_word #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] word_o
);
    logic [W-1:0] word_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       word_q <= '0;
        else if (wr_en_i) word_q <= wdata_i;
    end

    assign word_o = word_q;
endmodule

module data_memory #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned INDEX_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] q
);
    localparam int unsigned DEPTH = 1 << INDEX_BITS;

    logic [INDEX_BITS-1:0]             idx;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]  mem_q;

    // Upper address bits alias onto the low-order word index.
    assign idx = addr[INDEX_BITS-1:0];

    generate
        if (ADDR_WIDTH > INDEX_BITS) begin : g_hi_addr
            logic unused_hi_addr;
            assign unused_hi_addr = ^addr[ADDR_WIDTH-1:INDEX_BITS];
        end
    endgenerate

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_word
            data_memory_word #(.W(DATA_WIDTH)) u_word (
                .clk     (clk),
                .rst_n   (rst_n),
                .wr_en_i (we && (idx == INDEX_BITS'(g))),
                .wdata_i (data),
                .word_o  (mem_q[g])
            );
        end
    endgenerate

    // No write bypass: a same-index write only shows up after the edge.
    assign q = mem_q[idx];
endmodule

// File: tb/tb_data_memory.sv
// Table-driven bench for data_memory with a queue scoreboard and hand-written
// sequences for read-during-write, edge sampling and asynchronous reset.

module tb_data_memory;
    logic        clk;
    logic        rst_n;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] q;

    int nvec = 0;
    int nmis = 0;

    typedef struct {
        logic        we;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [31:0] raddr;
        logic [31:0] exp;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] exp;
        string       name;
    } sb_t;

    vec_t tbl[$];
    sb_t  sb[$];

    data_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .INDEX_BITS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .addr  (addr),
        .data  (data),
        .q     (q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push_exp(input string name, input logic [31:0] exp);
        sb_t e;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic compare();
        sb_t e;
        nvec++;
        if (sb.size() == 0) begin
            nmis++;
            $display("FAIL scoreboard_empty: q=%h with nothing expected", q);
        end else begin
            e = sb.pop_front();
            if (q !== e.exp) begin
                nmis++;
                $display("FAIL %s: q=%h expected %h", e.name, q, e.exp);
            end
        end
    endtask

    task automatic run_tbl(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            we   = tbl[i].we;
            addr = tbl[i].waddr;
            data = tbl[i].wdata;
            push_exp(tbl[i].name, tbl[i].exp);
            @(posedge clk);
            #1;
            we   = 1'b0;
            addr = tbl[i].raddr;
            #1;
            compare();
        end
    endtask

    initial begin
        // Part A: indices 0..9, part B (after a reset pulse): 10..15
        tbl.push_back('{1'b0, 32'd0,   32'd0,         32'd0,   32'd0,         "rd0_after_rst"});
        tbl.push_back('{1'b0, 32'd0,   32'd0,         32'd255, 32'd0,         "rd255_after_rst"});
        tbl.push_back('{1'b0, 32'd0,   32'd0,         32'd44,  32'd0,         "rd44_after_rst"});
        tbl.push_back('{1'b1, 32'd44,  32'd0,         32'd44,  32'd0,         "wr44_zero"});
        tbl.push_back('{1'b0, 32'd44,  32'h55,        32'd44,  32'd0,         "gated_write_55"});
        tbl.push_back('{1'b1, 32'd44,  32'd35,        32'd44,  32'd35,        "wr44_35"});
        tbl.push_back('{1'b0, 32'd44,  32'd99,        32'd44,  32'd35,        "hold35_edge1"});
        tbl.push_back('{1'b0, 32'd44,  32'd99,        32'd44,  32'd35,        "hold35_edge2"});
        tbl.push_back('{1'b1, 32'd77,  32'd99,        32'd44,  32'd35,        "wr77_rd44"});
        tbl.push_back('{1'b0, 32'd0,   32'd0,         32'd77,  32'd99,        "rd77"});
        tbl.push_back('{1'b1, 32'd300, 32'hDEADBEEF,  32'd44,  32'hDEADBEEF,  "alias300_rd44"});
        tbl.push_back('{1'b0, 32'd0,   32'd0,         32'd300, 32'hDEADBEEF,  "alias300_rd300"});
        tbl.push_back('{1'b1, 32'd255, 32'h0F0F0F0F,  32'd255, 32'h0F0F0F0F,  "wr255_top"});
        tbl.push_back('{1'b0, 32'd0,   32'd0,         32'd254, 32'd0,         "neighbour254"});
        tbl.push_back('{1'b0, 32'd0,   32'd0,         32'd0,   32'd0,         "neighbour0"});
        tbl.push_back('{1'b0, 32'd0,   32'd0,         32'd44,  32'hDEADBEEF,  "rd44_still"});

        rst_n = 1'b0;
        we    = 1'b0;
        addr  = 32'd44;
        data  = 32'd0;
        #3;
        push_exp("q_in_initial_reset", 32'd0);
        compare();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_tbl(0, 9);

        // Read-during-write: old word before the edge, new word after it.
        @(negedge clk);
        we = 1'b1; addr = 32'd44; data = 32'h1234;
        #1;
        push_exp("rdw_old_before_edge", 32'd35);
        compare();
        @(posedge clk);
        #1;
        push_exp("rdw_new_after_edge", 32'h1234);
        compare();

        // we dropped between edges: nothing stored.
        @(negedge clk);
        we = 1'b1; data = 32'hAAAA;
        #2;
        we = 1'b0; data = 32'hBBBB;
        @(posedge clk);
        #1;
        push_exp("we_glitch_ignored", 32'h1234);
        compare();

        // data changing between edges: value at the edge wins.
        @(negedge clk);
        we = 1'b1; data = 32'h1111;
        #2;
        data = 32'h2222;
        @(posedge clk);
        #1;
        we = 1'b0;
        push_exp("data_sampled_at_edge", 32'h2222);
        compare();

        // Asynchronous reset pulse between edges.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        push_exp("async_rst_44", 32'd0);
        compare();
        addr = 32'd77;
        #1;
        push_exp("async_rst_77", 32'd0);
        compare();
        we = 1'b1; addr = 32'd10; data = 32'hF0;
        @(posedge clk);
        #1;
        push_exp("write_during_rst", 32'd0);
        compare();
        we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        push_exp("rd10_after_rst", 32'd0);
        compare();

        run_tbl(10, 15);

        if (sb.size() != 0) begin
            nmis++;
            $display("FAIL scoreboard_leftover: %0d entries left, 0 expected", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
